bimodal_branch_predictor: RTL and testbench

Front-end branch predictor that closes the loop on branch resolution: the execute stage's branch unit writes resolved outcomes (taken flag, target, instruction type) into it, and fetch reads taken/target predictions from it one cycle after presenting a PC. It holds a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB). It sits between the fetch PC generator (lookup port) and the writeback of UNIT_BRANCH results (update port).

---
 rtl/bimodal_branch_predictor.sv | 103 ++++++++++
 tb/tb_bimodal_branch_predictor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bimodal_branch_predictor.sv
// Bimodal branch predictor: direct-mapped 2-bit counters plus a tagged BTB.
// The lookup result is registered, and the update port writes resolved branches.
module bimodal_branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int TAG_BITS = 10
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        lookup_valid_i,
    input  logic [63:0] lookup_pc_i,
    input  logic        stall_i,
    output logic        pred_valid_o,
    output logic        pred_hit_o,
    output logic        pred_taken_o,
    output logic [63:0] pred_target_o,
    input  logic        update_valid_i,
    input  logic [63:0] update_pc_i,
    input  logic        update_cond_i,
    input  logic        update_taken_i,
    input  logic [63:0] update_target_i,
    output logic [31:0] mispred_cnt_o
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [63:0]         target_q [ENTRIES];
    logic [31:0]         mispred_q;

    logic [IDX_BITS-1:0] lk_idx, up_idx;
    logic [TAG_BITS-1:0] lk_tag, up_tag;
    logic                lk_hit, up_hit, stored_taken, mispredict, btb_write;
    logic [1:0]          ctr_next;
    logic                unused_pc_bits;

    assign lk_idx = lookup_pc_i[IDX_BITS+1:2];
    assign lk_tag = lookup_pc_i[TAG_HI:TAG_LO];
    assign up_idx = update_pc_i[IDX_BITS+1:2];
    assign up_tag = update_pc_i[TAG_HI:TAG_LO];
    assign unused_pc_bits = ^{lookup_pc_i[63:TAG_HI+1], lookup_pc_i[1:0],
                              update_pc_i[63:TAG_HI+1], update_pc_i[1:0]};

    assign lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign stored_taken = up_hit && ctr_q[up_idx][1];
    assign mispredict   = (stored_taken != update_taken_i) ||
                          (stored_taken && update_taken_i && (target_q[up_idx] != update_target_i));

    always_comb begin
        ctr_next  = ctr_q[up_idx];
        btb_write = 1'b0;
        if (update_cond_i) begin
            if (update_taken_i) begin
                if (ctr_q[up_idx] != 2'b11) ctr_next = ctr_q[up_idx] + 2'b01;
                btb_write = 1'b1;
            end else if (ctr_q[up_idx] != 2'b00) begin
                ctr_next = ctr_q[up_idx] - 2'b01;
            end
        end else begin
            ctr_next  = 2'b11;
            btb_write = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
            mispred_q     <= '0;
            pred_valid_o  <= 1'b0;
            pred_hit_o    <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
        end else begin
            if (!stall_i) begin
                pred_valid_o  <= lookup_valid_i;
                pred_hit_o    <= lookup_valid_i && lk_hit;
                pred_taken_o  <= lookup_valid_i && lk_hit && ctr_q[lk_idx][1];
                pred_target_o <= (lookup_valid_i && lk_hit) ? target_q[lk_idx] : '0;
            end
            if (update_valid_i) begin
                ctr_q[up_idx] <= ctr_next;
                if (btb_write) valid_q[up_idx] <= 1'b1;
                if (mispredict) mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    // Tag/target storage carries no reset; the valid bits guard it.
    always_ff @(posedge clk_i) begin
        if (update_valid_i && btb_write) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= update_target_i;
        end
    end

    assign mispred_cnt_o = mispred_q;
endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Self-checking bench for bimodal_branch_predictor: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_bimodal_branch_predictor;
    localparam int IDX_BITS = 6;
    localparam int TAG_BITS = 10;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lookup_valid, stall, update_valid, update_cond, update_taken;
    logic [63:0] lookup_pc, update_pc, update_target;
    logic        pred_valid, pred_hit, pred_taken;
    logic [63:0] pred_target;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    bimodal_branch_predictor #(.IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .lookup_valid_i(lookup_valid), .lookup_pc_i(lookup_pc), .stall_i(stall),
        .pred_valid_o(pred_valid), .pred_hit_o(pred_hit), .pred_taken_o(pred_taken),
        .pred_target_o(pred_target),
        .update_valid_i(update_valid), .update_pc_i(update_pc), .update_cond_i(update_cond),
        .update_taken_i(update_taken), .update_target_i(update_target),
        .mispred_cnt_o(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_valid [ENTRIES];
    longint unsigned m_tag [ENTRIES];
    logic [63:0] m_target [ENTRIES];
    int          m_ctr [ENTRIES];
    logic        e_valid, e_hit, e_taken;
    logic [63:0] e_target;
    logic [31:0] e_cnt;

    function automatic int idx_of(logic [63:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic longint unsigned tag_of(logic [63:0] pc);
        return (pc >> (IDX_BITS + 2)) % (64'd1 << TAG_BITS);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        e_valid = 0; e_hit = 0; e_taken = 0; e_target = '0; e_cnt = '0;
    endtask

    task automatic idle();
        lookup_valid = 0; lookup_pc = '0; stall = 0;
        update_valid = 0; update_pc = '0; update_cond = 0; update_taken = 0; update_target = '0;
    endtask

    task automatic set_update(logic [63:0] pc, logic cond, logic taken, logic [63:0] tgt);
        update_valid = 1; update_pc = pc; update_cond = cond;
        update_taken = taken; update_target = tgt;
    endtask

    task automatic set_lookup(logic [63:0] pc);
        lookup_valid = 1; lookup_pc = pc;
    endtask

    // Advance one clock, evolving the model from the pre-edge state.
    task automatic step();
        int  i;
        bit  hit, stored, mis;
        if (!stall) begin
            i = idx_of(lookup_pc);
            hit = lookup_valid && m_valid[i] && (m_tag[i] == tag_of(lookup_pc));
            e_valid  = lookup_valid;
            e_hit    = hit;
            e_taken  = hit && (m_ctr[i] >= 2);
            e_target = hit ? m_target[i] : 64'd0;
        end
        if (update_valid) begin
            i = idx_of(update_pc);
            stored = m_valid[i] && (m_tag[i] == tag_of(update_pc)) && (m_ctr[i] >= 2);
            mis = (stored != update_taken) || (stored && update_taken && m_target[i] != update_target);
            if (mis) e_cnt = e_cnt + 32'd1;
            if (!update_cond) m_ctr[i] = 3;
            else if (update_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            if (!update_cond || update_taken) begin
                m_valid[i] = 1; m_tag[i] = tag_of(update_pc); m_target[i] = update_target;
            end
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        rstn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b h=%b t=%b tgt=%h cnt=%0d exp all zero",
                     pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt);
        end
        rstn = 1;
        set_lookup(64'h8000_0000);
        step();
        checks++;
        if ({pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt} !== {3'b100, 64'd0, 32'd0}) begin
            errors++;
            $display("FAIL first_lookup got v=%b h=%b t=%b tgt=%h cnt=%0d exp v=1 h=0 t=0 tgt=0 cnt=0",
                     pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt);
        end
    endtask

    task automatic test_cond();
        set_update(64'h8000_0010, 1, 1, 64'h8000_0100);
        step();
        set_lookup(64'h8000_0010);
        step();
        checks++;
        if ({pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt} !== {3'b111, 64'h8000_0100, 32'd1}) begin
            errors++;
            $display("FAIL cond_taken got v=%b h=%b t=%b tgt=%h cnt=%0d exp 1 1 1 80000100 1",
                     pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt);
        end
        for (int k = 0; k < 4; k++) begin
            set_update(64'h8000_0010, 1, 0, 64'h8000_0014);
            step();
            set_lookup(64'h8000_0010);
            step();
            checks++;
            if ({pred_hit, pred_taken, pred_target, mispred_cnt} !== {2'b10, 64'h8000_0100, 32'd2}) begin
                errors++;
                $display("FAIL cond_not_taken[%0d] got h=%b t=%b tgt=%h cnt=%0d exp h=1 t=0 tgt=80000100 cnt=2",
                         k, pred_hit, pred_taken, pred_target, mispred_cnt);
            end
        end
    endtask

    task automatic test_jump();
        set_update(64'h8000_0020, 0, 1, 64'h8000_2000);
        step();
        set_update(64'h8000_0020, 0, 1, 64'h8000_3000);
        step();
        set_lookup(64'h8000_0020);
        step();
        checks++;
        if ({pred_hit, pred_taken, pred_target, mispred_cnt} !== {2'b11, 64'h8000_3000, 32'd4}) begin
            errors++;
            $display("FAIL jump_retarget got h=%b t=%b tgt=%h cnt=%0d exp h=1 t=1 tgt=80003000 cnt=4",
                     pred_hit, pred_taken, pred_target, mispred_cnt);
        end
    endtask

    task automatic test_same_cycle_and_stall();
        logic [66:0] held;
        set_lookup(64'h8000_0040);
        set_update(64'h8000_0040, 1, 1, 64'h8000_0500);
        step();
        checks++;
        if ({pred_valid, pred_hit, pred_target} !== {2'b10, 64'd0}) begin
            errors++;
            $display("FAIL same_cycle_no_bypass got v=%b h=%b tgt=%h exp v=1 h=0 tgt=0",
                     pred_valid, pred_hit, pred_target);
        end
        set_lookup(64'h8000_0040);
        step();
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 64'h8000_0500}) begin
            errors++;
            $display("FAIL after_update got h=%b t=%b tgt=%h exp h=1 t=1 tgt=80000500",
                     pred_hit, pred_taken, pred_target);
        end
        held = {pred_valid, pred_hit, pred_taken, pred_target};
        for (int k = 0; k < 3; k++) begin
            stall = 1;
            set_lookup(64'h8000_0010);
            if (k == 1) set_update(64'h8000_0060, 0, 1, 64'h8000_0600);
            step();
            checks++;
            if ({pred_valid, pred_hit, pred_taken, pred_target} !== held) begin
                errors++;
                $display("FAIL stall_hold[%0d] got %h exp %h", k,
                         {pred_valid, pred_hit, pred_taken, pred_target}, held);
            end
        end
        set_lookup(64'h8000_0060);
        step();
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 64'h8000_0600}) begin
            errors++;
            $display("FAIL update_during_stall got h=%b tgt=%h exp h=1 tgt=80000600", pred_hit, pred_target);
        end
    endtask

    task automatic test_alias();
        logic [63:0] a = 64'h8000_0080;
        logic [63:0] b = 64'h8000_0080 + (64'd1 << (IDX_BITS + 2));
        set_update(a, 1, 1, 64'h8000_0A00);
        step();
        set_update(b, 1, 1, 64'h8000_0B00);
        step();
        set_lookup(a);
        step();
        checks++;
        if ({pred_hit, pred_target} !== {1'b0, 64'd0}) begin
            errors++;
            $display("FAIL alias_evicted got h=%b tgt=%h exp h=0 tgt=0", pred_hit, pred_target);
        end
        set_lookup(b);
        step();
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {2'b11, 64'h8000_0B00}) begin
            errors++;
            $display("FAIL alias_hit got h=%b t=%b tgt=%h exp h=1 t=1 tgt=80000B00",
                     pred_hit, pred_taken, pred_target);
        end
    endtask

    task automatic test_random();
        logic [63:0] pc;
        for (int n = 0; n < 600; n++) begin
            stall = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0) begin
                pc = 64'h8000_0000 + (64'($urandom_range(0, 11)) << 2) + (64'($urandom_range(0, 2)) << 8);
                set_lookup(pc);
            end
            if ($urandom_range(0, 1) != 0) begin
                pc = 64'h8000_0000 + (64'($urandom_range(0, 11)) << 2) + (64'($urandom_range(0, 2)) << 8);
                set_update(pc, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                           64'h8000_4000 + (64'($urandom_range(0, 3)) << 4));
                if (!update_cond) update_taken = 1;
            end
            step();
            checks++;
            if ({pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt} !==
                {e_valid, e_hit, e_taken, e_target, e_cnt}) begin
                errors++;
                $display("FAIL random[%0d] got v=%b h=%b t=%b tgt=%h cnt=%0d exp v=%b h=%b t=%b tgt=%h cnt=%0d",
                         n, pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt,
                         e_valid, e_hit, e_taken, e_target, e_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        set_update(64'h8000_0030, 0, 1, 64'h8000_7000);
        step();
        set_lookup(64'h8000_0030);
        step();
        checks++;
        if ({pred_valid, pred_hit} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_hit got v=%b h=%b exp v=1 h=1", pred_valid, pred_hit);
        end
        #2 rstn = 0;
        #1;
        checks++;
        if ({pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b h=%b t=%b tgt=%h cnt=%0d exp all zero",
                     pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt);
        end
        model_reset();
        @(negedge clk);
        rstn = 1;
        set_lookup(64'h8000_0030);
        step();
        checks++;
        if ({pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt} !== {3'b100, 64'd0, 32'd0}) begin
            errors++;
            $display("FAIL post_reset_empty got v=%b h=%b t=%b tgt=%h cnt=%0d exp v=1 rest 0",
                     pred_valid, pred_hit, pred_taken, pred_target, mispred_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_cond();
        test_jump();
        test_same_cycle_and_stall();
        test_alias();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
